rob_retire: RTL and testbench
=============================

Name: rob_retire

Overview:
- In-order retirement buffer that closes the physical-register loop opened by the rename stage.
- Rename allocates a new physical register per instruction. This block records each renamed instruction in program order and tracks its completion.
- At in-order retirement it returns the displaced (previous) physical mapping to the rename free list via new_free/new_free_reg.
- It also publishes the committed arch->phys mapping for the retirement RAT.

Parameters:
- DEPTH, 16, number of buffer entries (power of two, >=2).
- TAG_W, 4, log2(DEPTH); width of entry tag.
- PHYS_W, 5, physical register index width (32 physical registers).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alloc  in  1  rename requests a new entry this cycle
- alloc_has_dest  in  1  instruction writes a register
- alloc_arch_dest  in  3  architectural dest (lc3b_reg)
- alloc_phys  in  PHYS_W  newly assigned physical dest
- alloc_old_phys  in  PHYS_W  physical reg previously mapped to alloc_arch_dest
- alloc_ready  out  1  space available (= !full)
- alloc_tag  out  TAG_W  tag the next accepted alloc receives (= tail index)
- complete  in  1  execution unit reports completion
- complete_tag  in  TAG_W  tag of completing entry
- new_free  out  1  pulse: new_free_reg goes back to the free list
- new_free_reg  out  PHYS_W  freed physical register
- retire_valid  out  1  pulse: one instruction retired
- retire_arch  out  3  retired architectural dest
- retire_phys  out  PHYS_W  retired physical dest (committed mapping)
- count  out  TAG_W+1  occupied entries
- empty  out  1  count == 0

Behaviour:
- Storage: circular buffer. Per entry: valid, done, has_dest, arch, phys, old_phys.
- Pointers: head (oldest) and tail (next free), each TAG_W+1 bits with a wrap bit.
- full = (head/tail indices equal and wrap bits differ). empty = (pointers fully equal).
- count = tail - head, modulo 2^(TAG_W+1).
- alloc_ready, alloc_tag, count and empty are combinational from registered pointers.
- Reset (synchronous, active-high):
  - head = tail = 0; all valid and done cleared.
  - new_free = 0, new_free_reg = 0, retire_valid = 0, retire_arch = 0, retire_phys = 0.
  - Resulting combinational outputs: count = 0, empty = 1, alloc_ready = 1, alloc_tag = 0.
  - Reset overrides any same-cycle alloc, complete or retire.
  - Reset mid-operation discards all entries; no frees are emitted for them.
- Allocate: on an edge with alloc && alloc_ready:
  - Write the entry at tail with valid = 1, done = 0 and all fields.
  - Increment tail.
  - alloc while full is ignored; no state change.
- Complete: on an edge with complete, if entry[complete_tag].valid then set done = 1.
  - complete to an invalid entry is ignored.
  - This includes the entry being allocated in the same cycle.
  - A repeated complete to an already-done entry is harmless.
- Retire (at most one per cycle, in order): on each edge, if entry[head].valid && entry[head].done:
  - Clear valid/done of that entry and increment head.
  - Register retire_valid = 1, retire_arch = arch, retire_phys = phys.
  - Register new_free = has_dest, new_free_reg = old_phys.
  - Otherwise retire_valid = 0 and new_free = 0; data outputs hold their previous values.
- Latency:
  - complete sampled at edge E sets done.
  - The retire decision is made at edge E+1; outputs are high for exactly the cycle after E+1.
  - Back-to-back done entries retire on consecutive cycles.
- Out-of-order completion: younger done entries wait until all older entries retire.
- Simultaneous events:
  - alloc, complete and retire in one cycle all take effect.
  - alloc_ready uses the count at cycle start, so alloc is refused when full even if an entry retires that edge.
  - A retire that empties the buffer together with an alloc leaves count = 1.
- Wrap-around: indices wrap modulo DEPTH; the wrap bit distinguishes full from empty.
- Free-list pairing: new_free/new_free_reg connect directly to the rename stage's free-return inputs. At most one free per cycle, matching its one-per-cycle return port.

Test Plan:
- Reset, then alloc {has_dest = 1, arch = 3, phys = 8, old_phys = 3} (tag 0); complete tag 0 at edge E -> new_free = 1, new_free_reg = 3, retire_valid = 1, retire_arch = 3, retire_phys = 8 in the cycle after E+1 only; empty = 1 afterwards.
- Alloc tags 0, 1, 2; complete 2, then 1 -> no retire; complete 0 -> retires 0, 1, 2 on three consecutive cycles, frees in tag order.
- Alloc 16 entries -> alloc_ready = 0, count = 16; a 17th alloc is ignored (tail unchanged); complete tag 0 and retire -> alloc_ready = 1 next cycle, count = 15.
- Alloc with has_dest = 0, complete -> retire_valid = 1, new_free = 0.
- Run 40 alloc/complete/retire cycles through index wrap -> frees match old_phys order exactly; count never exceeds 16; empty = 1 at the end.
- Alloc 5 entries, complete 2, assert reset in the same cycle as a complete -> count = 0, no new_free pulses, alloc_tag = 0; a new alloc gets tag 0.

Source files
------------

// File: rtl/rob_retire.sv
// In-order retirement buffer: records renamed instructions, tracks completion,
// and returns each displaced physical register to the rename free list at retirement.
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PHYS_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc,
    input  logic              alloc_has_dest,
    input  logic [2:0]        alloc_arch_dest,
    input  logic [PHYS_W-1:0] alloc_phys,
    input  logic [PHYS_W-1:0] alloc_old_phys,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              complete,
    input  logic [TAG_W-1:0]  complete_tag,
    output logic              new_free,
    output logic [PHYS_W-1:0] new_free_reg,
    output logic              retire_valid,
    output logic [2:0]        retire_arch,
    output logic [PHYS_W-1:0] retire_phys,
    output logic [TAG_W:0]    count,
    output logic              empty
);

    localparam int PTR_W = TAG_W + 1;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  w_valid_next;
    logic [DEPTH-1:0]  w_done_next;

    logic              r_has_dest [DEPTH];
    logic [2:0]        r_arch     [DEPTH];
    logic [PHYS_W-1:0] r_phys     [DEPTH];
    logic [PHYS_W-1:0] r_old_phys [DEPTH];

    logic              r_new_free;
    logic [PHYS_W-1:0] r_new_free_reg;
    logic              r_retire_valid;
    logic [2:0]        r_retire_arch;
    logic [PHYS_W-1:0] r_retire_phys;

    logic [TAG_W-1:0]  w_head_idx;
    logic [TAG_W-1:0]  w_tail_idx;
    logic              w_full;
    logic              w_alloc_fire;
    logic              w_retire;

    assign w_head_idx   = r_head[TAG_W-1:0];
    assign w_tail_idx   = r_tail[TAG_W-1:0];
    assign w_full       = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);
    assign w_alloc_fire = alloc && !w_full;
    assign w_retire     = r_valid[w_head_idx] && r_done[w_head_idx];

    assign alloc_ready  = !w_full;
    assign alloc_tag    = w_tail_idx;
    assign count        = r_tail - r_head;
    assign empty        = (r_head == r_tail);

    // Alloc and retire never hit the same entry: that would need a full buffer,
    // where alloc is refused. Complete sees only entries valid at cycle start.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_alloc_hit;
            logic w_retire_hit;
            logic w_complete_hit;

            assign w_alloc_hit    = w_alloc_fire && (w_tail_idx == TAG_W'(gi));
            assign w_retire_hit   = w_retire && (w_head_idx == TAG_W'(gi));
            assign w_complete_hit = complete && (complete_tag == TAG_W'(gi)) && r_valid[gi];

            assign w_valid_next[gi] = w_alloc_hit  ? 1'b1 :
                                      w_retire_hit ? 1'b0 : r_valid[gi];
            assign w_done_next[gi]  = (w_alloc_hit || w_retire_hit) ? 1'b0 :
                                      w_complete_hit ? 1'b1 : r_done[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_valid        <= '0;
            r_done         <= '0;
            r_new_free     <= 1'b0;
            r_new_free_reg <= '0;
            r_retire_valid <= 1'b0;
            r_retire_arch  <= '0;
            r_retire_phys  <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
            if (w_alloc_fire) begin
                r_tail <= r_tail + 1'b1;
            end
            r_retire_valid <= w_retire;
            r_new_free     <= w_retire && r_has_dest[w_head_idx];
            if (w_retire) begin
                r_head         <= r_head + 1'b1;
                r_retire_arch  <= r_arch[w_head_idx];
                r_retire_phys  <= r_phys[w_head_idx];
                r_new_free_reg <= r_old_phys[w_head_idx];
            end
        end
    end

    // Payload needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_has_dest[w_tail_idx] <= alloc_has_dest;
            r_arch[w_tail_idx]     <= alloc_arch_dest;
            r_phys[w_tail_idx]     <= alloc_phys;
            r_old_phys[w_tail_idx] <= alloc_old_phys;
        end
    end

    assign new_free     = r_new_free;
    assign new_free_reg = r_new_free_reg;
    assign retire_valid = r_retire_valid;
    assign retire_arch  = r_retire_arch;
    assign retire_phys  = r_retire_phys;

endmodule

// File: tb/tb_rob_retire.sv
// Directed self-checking bench for rob_retire: latency, ordering, full, wrap and reset.
module tb_rob_retire;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int PHYS_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc;
    logic              alloc_has_dest;
    logic [2:0]        alloc_arch_dest;
    logic [PHYS_W-1:0] alloc_phys;
    logic [PHYS_W-1:0] alloc_old_phys;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              complete;
    logic [TAG_W-1:0]  complete_tag;
    logic              new_free;
    logic [PHYS_W-1:0] new_free_reg;
    logic              retire_valid;
    logic [2:0]        retire_arch;
    logic [PHYS_W-1:0] retire_phys;
    logic [TAG_W:0]    count;
    logic              empty;

    int checks = 0;
    int errors = 0;
    logic [PHYS_W-1:0] exp_q[$];
    int frees_seen;

    always #5 clk = ~clk;

    rob_retire #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PHYS_W(PHYS_W)) dut (
        .clk(clk), .reset(reset),
        .alloc(alloc), .alloc_has_dest(alloc_has_dest), .alloc_arch_dest(alloc_arch_dest),
        .alloc_phys(alloc_phys), .alloc_old_phys(alloc_old_phys),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .complete(complete), .complete_tag(complete_tag),
        .new_free(new_free), .new_free_reg(new_free_reg),
        .retire_valid(retire_valid), .retire_arch(retire_arch), .retire_phys(retire_phys),
        .count(count), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (retire_valid)
            $display("retire arch=%0d phys=%0d new_free=%0d free_reg=%0d count=%0d",
                     retire_arch, retire_phys, new_free, new_free_reg, count);
    endtask

    task automatic idle();
        alloc    = 1'b0;
        complete = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_alloc(input logic hd, input logic [2:0] a,
                             input logic [PHYS_W-1:0] p, input logic [PHYS_W-1:0] op);
        alloc           = 1'b1;
        alloc_has_dest  = hd;
        alloc_arch_dest = a;
        alloc_phys      = p;
        alloc_old_phys  = op;
    endtask

    task automatic set_complete(input logic [TAG_W-1:0] t);
        complete     = 1'b1;
        complete_tag = t;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        alloc_has_dest  = 1'b0;
        alloc_arch_dest = '0;
        alloc_phys      = '0;
        alloc_old_phys  = '0;
        complete_tag    = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_tag", 32'(alloc_tag), 0);
        chk("rst_new_free", 32'(new_free), 0);
        chk("rst_free_reg", 32'(new_free_reg), 0);
        chk("rst_retire_valid", 32'(retire_valid), 0);
        chk("rst_retire_arch", 32'(retire_arch), 0);
        chk("rst_retire_phys", 32'(retire_phys), 0);

        // Single entry: exact retire latency
        set_alloc(1'b1, 3'd3, 5'd8, 5'd3);
        tick();
        idle();
        chk("t1_count", 32'(count), 1);
        set_complete(4'd0);
        tick();                              // edge E
        idle();
        chk("t1_rv_at_E", 32'(retire_valid), 0);
        tick();                              // edge E+1
        chk("t1_rv", 32'(retire_valid), 1);
        chk("t1_nf", 32'(new_free), 1);
        chk("t1_nf_reg", 32'(new_free_reg), 3);
        chk("t1_arch", 32'(retire_arch), 3);
        chk("t1_phys", 32'(retire_phys), 8);
        tick();
        chk("t1_rv_drop", 32'(retire_valid), 0);
        chk("t1_nf_drop", 32'(new_free), 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_hold_reg", 32'(new_free_reg), 3);

        // Out-of-order completion retires in order
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, 3'(i), 5'(20 + i), 5'(10 + i));
            tick();
        end
        idle();
        set_complete(4'd2);
        tick();
        set_complete(4'd1);
        tick();
        chk("t2_wait0", 32'(retire_valid), 0);
        idle();
        tick();
        chk("t2_wait1", 32'(retire_valid), 0);
        set_complete(4'd0);
        tick();
        idle();
        chk("t2_wait2", 32'(retire_valid), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_rv", 32'(retire_valid), 1);
            chk("t2_arch", 32'(retire_arch), 32'(i));
            chk("t2_free_reg", 32'(new_free_reg), 32'(10 + i));
        end
        tick();
        chk("t2_rv_end", 32'(retire_valid), 0);
        chk("t2_empty", 32'(empty), 1);

        // Full buffer: 17th alloc ignored
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(1'b1, 3'(i % 8), 5'(i + 16), 5'(i));
            tick();
        end
        chk("t3_ready_full", 32'(alloc_ready), 0);
        chk("t3_count_full", 32'(count), 16);
        set_alloc(1'b1, 3'd7, 5'd31, 5'd31);
        tick();
        idle();
        chk("t3_count_17", 32'(count), 16);
        chk("t3_tag_17", 32'(alloc_tag), 0);
        set_complete(4'd0);
        tick();
        idle();
        chk("t3_ready_E", 32'(alloc_ready), 0);
        tick();
        chk("t3_ready_after", 32'(alloc_ready), 1);
        chk("t3_count_after", 32'(count), 15);
        chk("t3_free_reg", 32'(new_free_reg), 0);
        chk("t3_phys", 32'(retire_phys), 16);

        // No destination: retires without a free
        do_reset();
        set_alloc(1'b0, 3'd5, 5'd9, 5'd7);
        tick();
        idle();
        set_complete(4'd0);
        tick();
        idle();
        tick();
        chk("t4_rv", 32'(retire_valid), 1);
        chk("t4_nf", 32'(new_free), 0);
        chk("t4_arch", 32'(retire_arch), 5);

        // Streaming through index wrap: frees in allocation order
        do_reset();
        frees_seen = 0;
        for (int k = 0; k < 40; k++) begin
            chk("t5_tag", 32'(alloc_tag), 32'(k % 16));
            set_alloc(1'b1, 3'(k % 8), 5'(k % 32), 5'((k * 7 + 3) % 32));
            exp_q.push_back(5'((k * 7 + 3) % 32));
            if (k >= 2) set_complete(4'((k - 2) % 16));
            else complete = 1'b0;
            tick();
            chk("t5_count_le16", 32'(count <= 5'd16), 1);
            if (new_free) begin
                chk("t5_q_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("t5_free_order", 32'(new_free_reg), 32'(exp_q.pop_front()));
                frees_seen++;
            end
        end
        idle();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) set_complete(4'd6);
            else if (k == 1) set_complete(4'd7);
            else complete = 1'b0;
            tick();
            if (new_free) begin
                chk("t5_q_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("t5_free_order", 32'(new_free_reg), 32'(exp_q.pop_front()));
                frees_seen++;
            end
        end
        chk("t5_empty", 32'(empty), 1);
        chk("t5_frees", 32'(frees_seen), 40);
        chk("t5_q_left", 32'(exp_q.size()), 0);

        // Reset mid-operation discards everything
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, 3'(i), 5'(i + 1), 5'(i + 25));
            tick();
        end
        idle();
        set_complete(4'd0);
        tick();
        chk("t6_nf_pre", 32'(new_free), 0);
        set_complete(4'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("t6_count", 32'(count), 0);
        chk("t6_nf", 32'(new_free), 0);
        chk("t6_rv", 32'(retire_valid), 0);
        chk("t6_tag", 32'(alloc_tag), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_nf_idle", 32'(new_free), 0);
        end
        chk("t6_new_tag", 32'(alloc_tag), 0);
        set_alloc(1'b1, 3'd2, 5'd14, 5'd9);
        tick();
        idle();
        chk("t6_count_new", 32'(count), 1);
        set_complete(4'd0);
        tick();
        idle();
        tick();
        chk("t6_rv_new", 32'(retire_valid), 1);
        chk("t6_free_new", 32'(new_free_reg), 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
